// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps one memory request in flight, holds one fetched
// word for decode, and discards responses that a redirect has made stale.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] Ins_out,
    output logic [31:0] PC4_out
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HAVE  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   fetch_addr_q;
    logic [XLEN-1:0]   buf_q;
    logic [XLEN-1:0]   target;

    // Redirect targets are forced to a word boundary.
    assign target = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC + XLEN'(4);
            fetch_addr_q <= RESET_PC;
            buf_q        <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            pc_q         <= target;
                            fetch_addr_q <= target;
                        end else begin
                            buf_q   <= imem_rdata;
                            pc_q    <= fetch_addr_q + XLEN'(4);
                            state_q <= S_HAVE;
                        end
                    end else if (redirect) begin
                        pc_q    <= target;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The in-flight request must finish before the new target is issued.
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (imem_ready) begin
                        fetch_addr_q <= redirect ? target : pc_q;
                        state_q      <= S_FETCH;
                    end
                end
                S_HAVE: begin
                    if (redirect) begin
                        pc_q         <= target;
                        fetch_addr_q <= target;
                        state_q      <= S_FETCH;
                    end else if (!stall) begin
                        fetch_addr_q <= pc_q;
                        state_q      <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // A redirect squashes the held word in the same cycle it arrives.
    assign imem_req  = !rst && (state_q != S_HAVE);
    assign imem_addr = fetch_addr_q;
    assign out_valid = !rst && (state_q == S_HAVE) && !redirect;
    assign Ins_out   = out_valid ? buf_q : '0;
    assign PC4_out   = rst ? RESET_PC : fetch_addr_q + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a program-order reference model checked every cycle.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h00003000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] Ins_out;
    logic [31:0] PC4_out;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .Ins_out     (Ins_out),
        .PC4_out     (PC4_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Program-order model: exp_pc is the address of the next instruction decode should see.
    logic [31:0] exp_pc = RPC;
    logic        held = 1'b0;
    logic        tainted = 1'b0;
    logic        outstanding = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req",   {31'd0, imem_req},  32'd0);
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_ins",   Ins_out, 32'd0);
            chk("rst_pc4",   PC4_out, RPC);
            exp_pc      = RPC;
            held        = 1'b0;
            tainted     = 1'b0;
            outstanding = 1'b0;
        end else begin
            chk("m_req", {31'd0, imem_req}, {31'd0, !held});
            if (outstanding) begin
                chk("m_addr_stable", imem_addr, prev_addr);
            end else if (imem_req) begin
                chk("m_new_addr", imem_addr, exp_pc);
            end
            chk("m_valid", {31'd0, out_valid}, {31'd0, held && !redirect});
            if (out_valid) begin
                chk("m_pc4", PC4_out, exp_pc + 32'd4);
                chk("m_ins", Ins_out, mem_word(exp_pc));
            end else begin
                chk("m_nop", Ins_out, 32'd0);
            end
            if (held) begin
                if (redirect) begin
                    held   = 1'b0;
                    exp_pc = redirect_pc & ~32'd3;
                end else if (!stall) begin
                    held   = 1'b0;
                    exp_pc = exp_pc + 32'd4;
                end
            end else if (imem_ready) begin
                if (redirect) exp_pc = redirect_pc & ~32'd3;
                else if (!tainted) held = 1'b1;
                tainted = 1'b0;
            end else if (redirect) begin
                exp_pc  = redirect_pc & ~32'd3;
                tainted = 1'b1;
            end
            outstanding = imem_req && !imem_ready;
            prev_addr   = imem_addr;
        end
    end

    task automatic drive(input logic r, input logic st, input logic rd,
                         input logic [31:0] rp, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; stall = st; redirect = rd; redirect_pc = rp; imem_ready = rdy;
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        // Streaming with zero-wait memory.
        drive(0, 0, 0, 0, 1);
        chk("c0_req", {31'd0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h3000);
        chk("c0_valid", {31'd0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 1);
        chk("c1_pc4", PC4_out, 32'h3004);
        chk("c1_ins", Ins_out, 32'hDEAD3000);
        drive(0, 0, 0, 0, 1);
        chk("c2_addr", imem_addr, 32'h3004);
        drive(0, 0, 0, 0, 1);
        chk("c3_pc4", PC4_out, 32'h3008);
        drive(0, 0, 0, 0, 1);
        chk("c4_addr", imem_addr, 32'h3008);
        // Stall three cycles while holding.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 1);
            chk("stall_pc4", PC4_out, 32'h300C);
            chk("stall_ins", Ins_out, 32'hDEAD3008);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        drive(0, 0, 0, 0, 1);
        chk("unstall_valid", {31'd0, out_valid}, 32'd1);
        drive(0, 0, 0, 0, 1);
        chk("after_stall_addr", imem_addr, 32'h300C);
        // Redirect while held and stalled.
        drive(0, 1, 1, 32'h3100, 1);
        chk("sq_valid", {31'd0, out_valid}, 32'd0);
        chk("sq_ins", Ins_out, 32'd0);
        // Redirect while request pending, two wait cycles.
        drive(0, 0, 1, 32'h3200, 0);
        chk("r1_addr", imem_addr, 32'h3100);
        drive(0, 0, 0, 0, 0);
        chk("r2_addr", imem_addr, 32'h3100);
        drive(0, 0, 0, 0, 1);
        chk("r3_addr", imem_addr, 32'h3100);
        chk("r3_valid", {31'd0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 1);
        chk("r4_addr", imem_addr, 32'h3200);
        drive(0, 0, 0, 0, 1);
        chk("r5_pc4", PC4_out, 32'h3204);
        chk("r5_ins", Ins_out, 32'hDEAD3200);
        // Two redirects while draining.
        drive(0, 0, 1, 32'h3300, 0);
        chk("d1_addr", imem_addr, 32'h3204);
        drive(0, 0, 1, 32'h3400, 0);
        chk("d2_addr", imem_addr, 32'h3204);
        drive(0, 0, 0, 0, 1);
        chk("d3_valid", {31'd0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 1);
        chk("d4_addr", imem_addr, 32'h3400);
        drive(0, 0, 0, 0, 1);
        chk("d5_pc4", PC4_out, 32'h3404);
        // Redirect on the cycle the drain completes.
        drive(0, 0, 1, 32'h3500, 0);
        drive(0, 0, 1, 32'h3600, 1);
        drive(0, 0, 0, 0, 1);
        chk("d6_addr", imem_addr, 32'h3600);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        // Reset while 0x3010 is pending.
        drive(0, 0, 1, 32'h3010, 1);
        drive(0, 0, 0, 0, 0);
        chk("p_addr", imem_addr, 32'h3010);
        drive(1, 0, 0, 0, 0);
        chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
        drive(1, 1, 1, 32'h3700, 1);
        chk("rst_over_req", {31'd0, imem_req}, 32'd0);
        chk("rst_over_pc4", PC4_out, 32'h3000);
        drive(0, 0, 0, 0, 0);
        chk("rel_addr", imem_addr, 32'h3000);
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_valid", {31'd0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("rel2_valid", {31'd0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("rel_pc4", PC4_out, 32'h3004);
        // Redirect on completion, misaligned target, and address wrap.
        drive(0, 0, 1, 32'hFFFFFFFF, 1);
        chk("w0_addr", imem_addr, 32'h3004);
        drive(0, 0, 0, 0, 1);
        chk("w1_addr", imem_addr, 32'hFFFFFFFC);
        drive(0, 0, 0, 0, 1);
        chk("w2_pc4", PC4_out, 32'h0);
        chk("w2_ins", Ins_out, 32'h2152FFFC);
        drive(0, 0, 0, 0, 1);
        chk("w3_addr", imem_addr, 32'h0);
        // Mixed traffic, checked by the model only.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0),
                  $urandom,
                  ($urandom_range(0, 1) == 0));
        end
        drive(0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000: first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  decode stage cannot accept this cycle; IF_ID En is driven externally as !stall.
REQ-005 redirect  input  1  branch/jump taken this cycle.
REQ-006 redirect_pc  input  32  target address for redirect; bits [1:0] ignored and treated as 0.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  request address, word aligned.
REQ-009 imem_ready  input  1  memory completes the request this cycle.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-011 out_valid  output  1  Ins_out/PC4_out hold a live instruction.
REQ-012 Ins_out  output  32  instruction to IF_ID; 32'h0 (nop) whenever out_valid=0.
REQ-013 PC4_out  output  32  fetch address of Ins_out plus 4.

Function
REQ-014 Registers: pc (next address to fetch), fetch_addr (address of outstanding or held fetch), instr buffer, state.
REQ-015 States: FETCH (request outstanding), HAVE (instruction held for decode), DRAIN (outstanding request being discarded).
REQ-016 imem_req SHALL be 1 in FETCH and DRAIN and 0 in HAVE; imem_addr SHALL equal fetch_addr.
REQ-017 imem_addr SHALL remain stable from request assertion until the cycle imem_ready=1; a request SHALL never be withdrawn before completion.
REQ-018 FETCH, imem_ready=1, redirect=0: buffer <= imem_rdata; pc <= fetch_addr+4; next state HAVE.
REQ-019 FETCH, imem_ready=1, redirect=1: discard data; fetch_addr <= pc <= redirect_pc; stay in FETCH.
REQ-020 FETCH, imem_ready=0, redirect=1: pc <= redirect_pc; next state DRAIN.
REQ-021 DRAIN, imem_ready=1: discard data; fetch_addr <= pc; next state FETCH.
REQ-022 DRAIN, redirect=1: pc <= redirect_pc (latest redirect wins); if imem_ready=1 in the same cycle, fetch_addr <= redirect_pc.
REQ-023 HAVE: out_valid = !redirect (combinational); Ins_out = buffer; PC4_out = fetch_addr+4.
REQ-024 HAVE, redirect=0, stall=0: instruction accepted at this edge; fetch_addr <= pc; next state FETCH.
REQ-025 HAVE, stall=1, redirect=0: hold all outputs and state; no memory request.
REQ-026 HAVE, redirect=1: squash the held instruction (Ins_out=0 that cycle, regardless of stall); fetch_addr <= pc <= redirect_pc; next state FETCH.
REQ-027 Redirect has priority over stall in every state; stall has no effect in FETCH or DRAIN.
REQ-028 There is no delay-slot handling in this block: redirect squashes every younger instruction.
REQ-029 Address arithmetic is 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-030 Throughput: at most one instruction per two cycles; with zero-wait memory, latency from fetch request to out_valid is 1 cycle.

Reset
REQ-031 While rst=1: state <= FETCH; pc <= RESET_PC+4; fetch_addr <= RESET_PC; buffer <= 0; imem_req forced 0; out_valid=0; Ins_out=0; PC4_out=RESET_PC.
REQ-032 rst overrides redirect, stall and imem_ready.
REQ-033 Reset mid-transaction abandons the request; the first cycle after rst falls asserts imem_req with imem_addr=32'h00003000.

Verification
REQ-034 Reset release, imem_ready=1 always, stall=0 -> addresses 0x3000, 0x3004, 0x3008 requested on alternate cycles; PC4_out 0x3004, 0x3008, 0x300C with matching Ins_out.
REQ-035 Instruction held in HAVE, stall=1 for 3 cycles -> Ins_out and PC4_out stable, imem_req=0; stall drops -> next request is fetch_addr+4.
REQ-036 Redirect to 0x3100 in HAVE while stall=1 -> Ins_out=0 that cycle; next imem_addr=0x3100.
REQ-037 Redirect to 0x3200 in FETCH with imem_ready=0 for 2 cycles -> imem_addr unchanged until ready; the returned word is never output; next request is 0x3200.
REQ-038 Two redirects during DRAIN (0x3300 then 0x3400) -> only 0x3400 is fetched.
REQ-039 rst asserted while the request for 0x3010 is pending -> imem_req=0; after release imem_addr=0x3000 and out_valid=0 until the first completion.
